// File: rtl/vec_strided_mem.sv
// ---------------------------------------------------------------------------
// vec_strided_mem
// Strided gather/scatter data memory for the vector CPU. One request moves
// LANES elements. Lane k lives at address (req_addr + k*req_stride), truncated
// to ADDR_W bits. PORTS lanes are handled per cycle, so a request takes
// NB = LANES/PORTS beats. Each lane has a mask bit. A masked-in lane whose
// address is at or beyond MEM_DEPTH is skipped and reported through err_oob.
//
// Ports
//   CLK, RST           clock and synchronous active-high reset
//   req_valid/ready    request handshake, described below
//   req_we             1 = scatter (write), 0 = gather (read)
//   req_addr           base address of lane 0
//   req_stride         address step between consecutive lanes
//   req_mask           per-lane enable; bit k controls lane k
//   wdata              per-lane write data; only the low ELEM_W bits are stored
//   done               one-cycle completion pulse
//   rdata              gather result; changes only together with done of a read
//   err_oob            qualified by done: an enabled lane was out of bounds
//   busy               high while beats are being transferred
//   dbg_state          current FSM state, for checkers
//
// Handshake: a request is taken on a rising edge where req_valid and req_ready
// are both high. req_ready is high only in IDLE and only while RST is low.
// Every request field is captured at that edge, and the inputs are ignored
// until the block returns to IDLE. There is no backpressure on the response:
// done is a single pulse that the consumer must catch.
// ---------------------------------------------------------------------------
module vec_strided_mem #(
    parameter int LANES     = 16,
    parameter int DATA_W    = 16,
    parameter int ELEM_W    = 8,
    parameter int MEM_DEPTH = 14400,
    parameter int ADDR_W    = 16,
    parameter int PORTS     = 4
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [ADDR_W-1:0]               req_stride,
    input  logic [LANES-1:0]                req_mask,
    input  logic [LANES-1:0][DATA_W-1:0]    wdata,
    output logic                            done,
    output logic [LANES-1:0][DATA_W-1:0]    rdata,
    output logic                            err_oob,
    output logic                            busy,
    output logic [1:0]                      dbg_state
);

    localparam int NB     = LANES / PORTS;
    localparam int BEAT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    if (LANES % PORTS != 0) begin : g_bad_ports
        $error("vec_strided_mem: LANES must be a multiple of PORTS");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                          state_q, state_d;
    logic [BEAT_W-1:0]               beat_q, beat_d;
    logic                            we_q, we_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [ADDR_W-1:0]               stride_q, stride_d;
    logic [LANES-1:0]                mask_q, mask_d;
    logic [LANES-1:0][DATA_W-1:0]    wdata_q, wdata_d;
    logic [LANES-1:0][DATA_W-1:0]    shadow_q, shadow_d;
    logic                            oob_q, oob_d;
    logic                            done_q, done_d;
    logic                            err_oob_q, err_oob_d;
    logic [LANES-1:0][DATA_W-1:0]    rdata_q, rdata_d;

    logic [ELEM_W-1:0] mem [MEM_DEPTH];

    // Per-port view of the current beat: lane number, address and status.
    logic [LANE_W-1:0] lane_num  [PORTS];
    logic [ADDR_W-1:0] lane_addr [PORTS];
    logic [ELEM_W-1:0] lane_rd   [PORTS];
    logic [PORTS-1:0]  lane_act;
    logic [PORTS-1:0]  lane_oob;

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        logic in_bounds;
        assign lane_num[p]  = LANE_W'(int'(beat_q) * PORTS + p);
        // Truncation to ADDR_W is intentional: addresses wrap modulo 2^ADDR_W,
        // never modulo MEM_DEPTH.
        assign lane_addr[p] = addr_q + ADDR_W'(lane_num[p]) * stride_q;
        assign in_bounds    = 32'(lane_addr[p]) < MEM_DEPTH;
        assign lane_act[p]  = mask_q[lane_num[p]] && in_bounds;
        assign lane_oob[p]  = mask_q[lane_num[p]] && !in_bounds;
        assign lane_rd[p]   = mem[MEM_AW'(lane_addr[p])];
    end

    // Scatter port. Ascending loop order means the highest port in a beat
    // wins when addresses collide, and later beats overwrite earlier ones.
    // RST blocks the write, so a beat that coincides with reset is dropped.
    always_ff @(posedge CLK) begin
        if (state_q == S_XFER && we_q && !RST) begin
            for (int p = 0; p < PORTS; p++) begin
                if (lane_act[p]) begin
                    mem[MEM_AW'(lane_addr[p])] <= wdata_q[lane_num[p]][ELEM_W-1:0];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        we_d      = we_q;
        addr_d    = addr_q;
        stride_d  = stride_q;
        mask_d    = mask_q;
        wdata_d   = wdata_q;
        shadow_d  = shadow_q;
        oob_d     = oob_q;
        done_d    = 1'b0;
        err_oob_d = 1'b0;
        rdata_d   = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    we_d     = req_we;
                    addr_d   = req_addr;
                    stride_d = req_stride;
                    mask_d   = req_mask;
                    wdata_d  = wdata;
                    beat_d   = '0;
                    oob_d    = 1'b0;
                    state_d  = S_XFER;
                end
            end
            S_XFER: begin
                for (int p = 0; p < PORTS; p++) begin
                    if (lane_oob[p]) begin
                        oob_d = 1'b1;
                    end
                    if (!we_q) begin
                        shadow_d[lane_num[p]] = lane_act[p] ? DATA_W'(lane_rd[p]) : '0;
                    end
                end
                if (beat_q == BEAT_W'(NB - 1)) begin
                    state_d = S_RESP;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_RESP: begin
                // done, err_oob and rdata are registered, so they become
                // visible in the cycle after RESP, when the block is IDLE again.
                done_d    = 1'b1;
                err_oob_d = oob_q;
                if (!we_q) begin
                    rdata_d = shadow_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            stride_q  <= '0;
            mask_q    <= '0;
            wdata_q   <= '0;
            shadow_q  <= '0;
            oob_q     <= 1'b0;
            done_q    <= 1'b0;
            err_oob_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            stride_q  <= stride_d;
            mask_q    <= mask_d;
            wdata_q   <= wdata_d;
            shadow_q  <= shadow_d;
            oob_q     <= oob_d;
            done_q    <= done_d;
            err_oob_q <= err_oob_d;
            rdata_q   <= rdata_d;
        end
    end

    assign req_ready = (state_q == S_IDLE) && !RST;
    assign busy      = (state_q == S_XFER);
    assign done      = done_q;
    assign err_oob   = err_oob_q;
    assign rdata     = rdata_q;
    assign dbg_state = state_q;

endmodule
